bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Loadable multi-digit BCD down-counter: the counting-down counterpart of the team's decade up-counter. Software or a controlling FSM loads a BCD start value; each enabled clock decrements it one count with decade borrow between digits. `done` pulses for one cycle when the value reaches zero, and `cnt` can drive the same BCD display path as the up-counter.

## Interface
- `DIGITS`, default 2: number of cascaded BCD decades. Legal range is 1 to 8.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `enable` input, 1 bit: count qualifier; one decrement per enabled cycle.
- `load` input, 1 bit: synchronous load strobe.
- `load_val` input, `4*DIGITS` bits: BCD start value; digit 0 is in bits [3:0].
- `cnt` output, `4*DIGITS` bits: current BCD value, registered.
- `busy` output, 1 bit: registered; high while counting toward zero.
- `zero` output, 1 bit: `cnt` equals all zeros; decoded from `cnt` only.
- `done` output, 1 bit: registered one-cycle pulse on the 1 → 0 decrement.

## Operation
- **Reset (async):**
  - `cnt`, the reload register, `busy` and `done` clear to 0.
  - `zero` is 1.
  - Reset mid-count aborts immediately; no `done` is produced.
- **Load:**
  - `load`=1 copies `load_val` into `cnt` and into the reload register.
  - Any input digit greater than 9 is clamped to 9 per digit.
  - `busy` is set to 1 if the clamped value is nonzero, otherwise 0.
  - `done`=0 that cycle.
- **Priority:** `reset` > `load` > `enable`. With `load` and `enable` both high, the load happens and no decrement occurs.
- **Decrement (`enable`=1, `busy`=1):**
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - Borrow ripples within the same cycle across all digits.
- **Reaching zero:** on the decrement from value 1 to 0:
  - `cnt` becomes 0.
  - `done`=1 for that cycle only.
  - `busy`=0.
- **`enable`=0:** `cnt`, `busy` hold and `done`=0.
- **States:**
  - IDLE (`busy`=0) → COUNT on a nonzero load.
  - COUNT → IDLE on the 1 → 0 decrement.
  - COUNT → COUNT on a reload.
  - IDLE → IDLE on a zero load.
- **No underflow:** `enable` in IDLE with `cnt`=0 holds at 0. There is no wrap to all-9s (non-reload build).

## Timing
- `cnt`, `busy` and `done` update on the `clk` edge after the qualifying input; latency is 1 cycle.
- `zero` follows `cnt` combinationally, with no input-to-output path.
- A value of N needs exactly N enabled cycles from load to the `done` pulse. Disabled cycles stretch this without limit.
- The `done` pulse width is exactly 1 clock, independent of `enable` in the following cycle.
- Back-to-back loads: the last load wins. A load in the same cycle as the 1 → 0 decrement suppresses `done`.

## Configuration
- Macro: `BCD_TIMER_AUTO_RELOAD_EN`.
- **Defined:**
  - On the 1 → 0 decrement `done` pulses, `cnt` shows 0 and `busy` stays 1.
  - On the next enabled cycle, `cnt` reloads from the reload register.
  - Period = N+1 enabled cycles per `done`.
  - A load of 0 leaves the block in IDLE with no auto reload.
- **Undefined:** the block is one-shot, as described in Operation. The reload register is not synthesised.

## Structure
- Shared package `bcd_pkg`:
  - `BCD_W`=4, `BCD_MAX`=4'd9.
  - `typedef logic [3:0] bcd_digit_t`.
  - Function `bcd_clamp()`.
- Sub-module `decade_down_stage`:
  - Ports: one digit register, `borrow_in`, `borrow_out`, `load`, `load_digit`.
  - Instantiated `DIGITS` times through a generate loop.
  - The top level holds the busy/done FSM and the reload register.

## Test plan
All scenarios use `DIGITS`=2.
- Reset asserted mid-count at `cnt`=8'h37 → `cnt`=8'h00, `busy`=0, `zero`=1, `done`=0 asynchronously, before the next clock edge.
- Load 8'h12, `enable` held high → `cnt` sequence 12, 11, 10, 09 … 01, 00. The 10 → 09 step shows the borrow. `done` high only on the cycle `cnt` becomes 00, after exactly 12 enabled cycles.
- Load 8'h05, toggle `enable` 1/0 → `done` after exactly 5 enabled cycles; `cnt` holds while disabled.
- Load 8'hAF → `cnt`=8'h99 (clamped), `busy`=1. Load 8'h00 → `busy`=0, no `done`.
- `load`=1 with `enable`=1 at `cnt`=8'h01, `load_val`=8'h03 → `cnt`=8'h03, no `done`. Then `enable` held in IDLE at 00 → `cnt` stays 00.
- With `BCD_TIMER_AUTO_RELOAD_EN`, load 8'h03 → `cnt` 03, 02, 01, 00, 03, 02 …, with `done` every 4 enabled cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the decade counters: digit type, limits and the
// per-digit clamp applied to loaded values.
package bcd_pkg;
  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } timer_state_e;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/decade_down_stage.sv
// One BCD decade of the down-counter. borrow_in means "every lower digit is 0";
// the digit decrements when dec is high and borrow_in is set.
module decade_down_stage
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       dec,
  input  logic       borrow_in,
  output logic       borrow_out,
  output bcd_digit_t digit
);
  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (dec && borrow_in) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) digit_q <= '0;
    else       digit_q <= digit_d;
  end

  assign borrow_out = borrow_in & (digit_q == '0);
  assign digit      = digit_q;
endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD down-counter with a one-cycle done pulse at zero.
// Optional macro BCD_TIMER_AUTO_RELOAD_EN reloads the start value after zero.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  busy,
  output logic                  zero,
  output logic                  done
);
  // load and enable are level qualifiers sampled at each rising edge; there is
  // no backpressure, and load always overrides enable in the same cycle.
  timer_state_e        state_q, state_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] load_clamped;
  logic [4*DIGITS-1:0] stage_load_val;
  logic [DIGITS:0]     borrow;
  logic                stage_load;
  logic                dec_en;
  logic                is_one;
  logic                reload_fire;

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[i*BCD_W +: BCD_W] = bcd_clamp(load_val[i*BCD_W +: BCD_W]);
    end
  end

  // The borrow chain doubles as the zero detector: the top borrow is set only
  // when every digit is 0.
  assign borrow[0] = 1'b1;
  assign zero      = borrow[DIGITS];
  assign is_one    = (cnt == (4*DIGITS)'(1));

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [4*DIGITS-1:0] reload_q, reload_d;

  always_comb begin
    reload_d = load ? load_clamped : reload_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) reload_q <= '0;
    else       reload_q <= reload_d;
  end

  // A busy counter sitting at 0 restarts from the stored start value.
  assign reload_fire    = enable & ~load & (state_q == ST_COUNT) & zero;
  assign stage_load_val = load ? load_clamped : reload_q;
`else
  assign reload_fire    = 1'b0;
  assign stage_load_val = load_clamped;
`endif

  assign stage_load = load | reload_fire;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    dec_en  = 1'b0;
    if (load) begin
      state_d = (load_clamped != '0) ? ST_COUNT : ST_IDLE;
    end else if (enable && (state_q == ST_COUNT) && !reload_fire) begin
      dec_en = 1'b1;
      if (is_one) begin
        done_d = 1'b1;
`ifndef BCD_TIMER_AUTO_RELOAD_EN
        state_d = ST_IDLE;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    decade_down_stage u_stage (
      .clk        (clk),
      .reset      (reset),
      .load       (stage_load),
      .load_digit (stage_load_val[g*BCD_W +: BCD_W]),
      .dec        (dec_en),
      .borrow_in  (borrow[g]),
      .borrow_out (borrow[g+1]),
      .digit      (cnt[g*BCD_W +: BCD_W])
    );
  end

  assign busy = (state_q == ST_COUNT);
  assign done = done_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer (DIGITS=2): directed scenarios plus a random
// run, all checked against an integer-valued reference model.
module tb_bcd_countdown_timer;
  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt;
  logic         busy;
  logic         zero;
  logic         done;

  int total = 0;
  int bad   = 0;

  int m_val;
  int m_reload;
  bit m_busy;
  bit m_done;

  bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .busy     (busy),
    .zero     (zero),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic int clamp_val(input logic [W-1:0] lv);
    int v = 0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int d;
      d = int'(lv[i*4 +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_reload = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_step(input bit l, input logic [W-1:0] lv, input bit en);
    m_done = 0;
    if (l) begin
      m_val    = clamp_val(lv);
      m_reload = m_val;
      m_busy   = (m_val != 0);
    end else if (en && m_busy) begin
      if (AUTO_RELOAD && m_val == 0) begin
        m_val = m_reload;
      end else begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_done = 1;
          if (!AUTO_RELOAD) m_busy = 0;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit l, input logic [W-1:0] lv, input bit en);
    load = l; load_val = lv; enable = en;
    @(posedge clk);
    model_step(l, lv, en);
    #1;
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; enable = 1'b0; load_val = '0;
    model_reset();
    #12;
    total++; if (cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt: got %h want 00", cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", zero); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_countdown_12();
    step(1'b1, 8'h12, 1'b0);
    total++; if (cnt !== 8'h12 || busy !== 1'b1) begin bad++; $display("FAIL cd12_load: got cnt=%h busy=%b want 12/1", cnt, busy); end
    for (int i = 1; i <= 12; i++) begin
      logic [W-1:0] exp_cnt;
      bit exp_busy;
      step(1'b0, 8'h00, 1'b1);
      exp_cnt  = to_bcd(12 - i);
      exp_busy = AUTO_RELOAD ? 1'b1 : (i < 12);
      total++;
      if (cnt !== exp_cnt || done !== (i == 12) || busy !== exp_busy || zero !== (i == 12)) begin
        bad++;
        $display("FAIL cd12_step%0d: got cnt=%h done=%b busy=%b zero=%b want %h/%b/%b/%b",
                 i, cnt, done, busy, zero, exp_cnt, (i == 12), exp_busy, (i == 12));
      end
    end
    step(1'b0, 8'h00, 1'b0);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL cd12_pulse_width: got done=%b want 0", done); end
  endtask

  task automatic test_gated_5();
    int n = 0;
    step(1'b1, 8'h05, 1'b0);
    for (int k = 0; k < 20 && n < 5; k++) begin
      bit en;
      en = (k % 2 == 0);
      step(1'b0, 8'h00, en);
      if (en) n++;
      total++;
      if (cnt !== to_bcd(5 - n) || done !== (en && n == 5)) begin
        bad++;
        $display("FAIL gated5_k%0d: got cnt=%h done=%b want %h/%b", k, cnt, done, to_bcd(5 - n), (en && n == 5));
      end
    end
  endtask

  task automatic test_clamp_zero_load();
    step(1'b1, 8'hAF, 1'b0);
    total++; if (cnt !== 8'h99 || busy !== 1'b1 || zero !== 1'b0) begin bad++; $display("FAIL clamp_af: got cnt=%h busy=%b zero=%b want 99/1/0", cnt, busy, zero); end
    step(1'b1, 8'h00, 1'b0);
    total++; if (cnt !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin bad++; $display("FAIL load_zero: got cnt=%h busy=%b done=%b zero=%b want 00/0/0/1", cnt, busy, done, zero); end
  endtask

  task automatic test_load_priority();
    step(1'b1, 8'h01, 1'b0);
    total++; if (cnt !== 8'h01) begin bad++; $display("FAIL prio_setup: got cnt=%h want 01", cnt); end
    step(1'b1, 8'h03, 1'b1);
    total++; if (cnt !== 8'h03 || done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL prio_load: got cnt=%h done=%b busy=%b want 03/0/1", cnt, done, busy); end
    step(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (cnt !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL no_underflow_%0d: got cnt=%h done=%b busy=%b want 00/0/0", i, cnt, done, busy); end
    end
  endtask

  task automatic test_reset_midcount();
    step(1'b1, 8'h37, 1'b0);
    total++; if (cnt !== 8'h37) begin bad++; $display("FAIL mid_setup: got cnt=%h want 37", cnt); end
    reset = 1'b1;
    #2;
    total++; if (cnt !== 8'h00 || busy !== 1'b0 || zero !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL mid_reset: got cnt=%h busy=%b zero=%b done=%b want 00/0/1/0", cnt, busy, zero, done); end
    #2;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (cnt !== 8'h00 || done !== 1'b0) begin bad++; $display("FAIL mid_after_%0d: got cnt=%h done=%b want 00/0", i, cnt, done); end
    end
  endtask

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    int exp_v[8] = '{2, 1, 0, 3, 2, 1, 0, 3};
    step(1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++;
      if (cnt !== to_bcd(exp_v[i]) || done !== (i == 2 || i == 6) || busy !== 1'b1) begin
        bad++;
        $display("FAIL autoreload_%0d: got cnt=%h done=%b busy=%b want %h/%b/1", i, cnt, done, busy, to_bcd(exp_v[i]), (i == 2 || i == 6));
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit l;
      bit en;
      logic [W-1:0] lv;
      l  = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       lv = W'($urandom);
        1:       lv = {4'h0, 4'($urandom_range(0, 9))};
        default: lv = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      endcase
      step(l, lv, en);
      total++;
      if (cnt !== to_bcd(m_val) || busy !== m_busy || done !== m_done || zero !== (m_val == 0)) begin
        bad++;
        $display("FAIL random_%0d: got cnt=%h busy=%b done=%b zero=%b want %h/%b/%b/%b",
                 i, cnt, busy, done, zero, to_bcd(m_val), m_busy, m_done, (m_val == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown_12();
    test_gated_5();
    test_clamp_zero_load();
    test_load_priority();
    test_reset_midcount();
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
